// File: rtl/gpio_input_debounce_pkg.sv
// rtl/gpio_input_debounce_pkg.sv - shared GPIO input constants and debounce types
package gpio_input_debounce_pkg;

  localparam int GPIO_IN_WIDTH           = 21;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_COUNTING = 1'b1
  } deb_state_e;

  // Counter must hold values up to DEBOUNCE_CYCLES-1 without ever wrapping.
  function automatic int cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/gpio_input_debounce_bit.sv
// rtl/gpio_input_debounce_bit.sv - one-line synchronizer, debounce counter and edge pulses
module debounce_bit
  import gpio_input_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_data,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CW-1:0]          cnt;
  logic                   stable;
  deb_state_e             state;

  always_ff @(posedge i_clk) begin
    if (i_reset) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], i_raw};
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // A change is accepted on the DEBOUNCE_CYCLES-th consecutive mismatching cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      stable <= 1'b0;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      o_rise <= 1'b0;
      o_fall <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sync != stable) begin
            if (LAST == '0) begin
              stable <= sync;
              o_rise <= sync;
              o_fall <= ~sync;
            end else begin
              cnt   <= CW'(1);
              state <= ST_COUNTING;
            end
          end
        end
        ST_COUNTING: begin
          if (sync == stable) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else if (cnt == LAST) begin
            stable <= sync;
            o_rise <= sync;
            o_fall <= ~sync;
            cnt    <= '0;
            state  <= ST_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_data = stable;

endmodule

// File: rtl/gpio_input_debounce.sv
// rtl/gpio_input_debounce.sv - per-line debounce array for switch and button inputs
module gpio_input_debounce
  import gpio_input_debounce_pkg::*;
#(
  parameter int WIDTH           = GPIO_IN_WIDTH,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_data,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic             o_changed
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .i_raw  (i_raw[i]),
      .o_data (o_data[i]),
      .o_rise (o_rise[i]),
      .o_fall (o_fall[i])
    );
  end

  assign o_changed = |(o_rise | o_fall);

endmodule

// File: tb/tb_gpio_input_debounce.sv
// tb/tb_gpio_input_debounce.sv - self-checking bench for gpio_input_debounce
module tb_gpio_input_debounce;

  localparam int W = 21;
  localparam int D = 4;
  localparam int S = 2;
  localparam logic [W-1:0] ALL = 21'h1FFFFF;

  logic         i_clk = 1'b0;
  logic         i_reset = 1'b1;
  logic [W-1:0] i_raw = '0;
  logic [W-1:0] o_data, o_rise, o_fall;
  logic         o_changed;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic         rst;
    logic [W-1:0] raw;
    logic [W-1:0] data;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         chg;
  } vec_t;

  vec_t tbl[$];

  // Reference: raw history since last reset; a bit flips once its last D synced samples all disagree.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_data = '0, m_rise = '0, m_fall = '0;

  gpio_input_debounce #(
    .WIDTH          (W),
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_raw    (i_raw),
    .o_data   (o_data),
    .o_rise   (o_rise),
    .o_fall   (o_fall),
    .o_changed(o_changed)
  );

  always #5 i_clk = ~i_clk;

  task automatic add(input logic rst, input logic [W-1:0] raw, input logic [W-1:0] data,
                     input logic [W-1:0] rise, input logic [W-1:0] fall, input logic chg);
    vec_t v;
    v.rst = rst; v.raw = raw; v.data = data; v.rise = rise; v.fall = fall; v.chg = chg;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rst, input logic [W-1:0] raw);
    logic [W-1:0] diff, s;
    int n, e;
    if (rst) begin
      hist.delete();
      m_data = '0; m_rise = '0; m_fall = '0;
    end else begin
      hist.push_back(raw);
      n = hist.size() - 1;
      diff = ALL;
      for (int k = 0; k < D; k++) begin
        e = n - k;
        s = (e >= S) ? hist[e-S] : '0;
        diff &= s ^ m_data;
      end
      m_rise = diff & ~m_data;
      m_fall = diff & m_data;
      m_data = m_data ^ diff;
    end
  endtask

  task automatic step(input logic rst, input logic [W-1:0] raw);
    i_reset = rst;
    i_raw   = raw;
    @(posedge i_clk);
    model_edge(rst, raw);
    @(negedge i_clk);
  endtask

  initial begin
    logic [W-1:0] base, r, flip;

    // Reset with all lines high, release, full-latency acceptance
    add(1, ALL, 0, 0, 0, 0);
    add(1, ALL, 0, 0, 0, 0);
    repeat (5) add(0, ALL, 0, 0, 0, 0);
    add(0, ALL, ALL, ALL, 0, 1);
    add(0, ALL, ALL, 0, 0, 0);
    // Reset with lines low: no fall pulses
    add(1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    // Bit 0 rises
    repeat (5) add(0, 21'h1, 0, 0, 0, 0);
    add(0, 21'h1, 21'h1, 21'h1, 0, 1);
    add(0, 21'h1, 21'h1, 0, 0, 0);
    // Bit 5 glitch of three cycles
    repeat (3) add(0, 21'h21, 21'h1, 0, 0, 0);
    repeat (5) add(0, 21'h1, 21'h1, 0, 0, 0);
    // Bit 3 rises
    repeat (5) add(0, 21'h9, 21'h1, 0, 0, 0);
    add(0, 21'h9, 21'h9, 21'h8, 0, 1);
    add(0, 21'h9, 21'h9, 0, 0, 0);
    // Bit 20 rises while bit 3 falls
    repeat (5) add(0, 21'h100001, 21'h9, 0, 0, 0);
    add(0, 21'h100001, 21'h100001, 21'h100000, 21'h8, 1);
    add(0, 21'h100001, 21'h100001, 0, 0, 0);

    @(negedge i_clk);
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].raw);
      chk($sformatf("tbl%0d_data", i), o_data, tbl[i].data);
      chk($sformatf("tbl%0d_rise", i), o_rise, tbl[i].rise);
      chk($sformatf("tbl%0d_fall", i), o_fall, tbl[i].fall);
      chk($sformatf("tbl%0d_chg", i), W'(o_changed), W'(tbl[i].chg));
    end

    // Bit 7 bounce 1,0,1,1,1,1: counter restarts, accepted after edge 7
    base = 21'h100001;
    for (int k = 0; k < 10; k++) begin
      r = base | ((k == 1) ? 21'h0 : 21'h80);
      step(0, r);
      chk($sformatf("bounce%0d_data", k), o_data, (k >= 7) ? (base | 21'h80) : base);
      chk($sformatf("bounce%0d_rise", k), o_rise, (k == 7) ? 21'h80 : 21'h0);
    end

    // Reset while bit 2 counts at 2, then full latency after release
    base = 21'h100085;
    for (int k = 0; k < 4; k++) step(0, base);
    step(1, base);
    chk("midrst_data", o_data, 0);
    chk("midrst_rise", o_rise, 0);
    for (int k = 0; k < 7; k++) begin
      step(0, base);
      chk($sformatf("postrst%0d_data", k), o_data, (k >= 5) ? base : 21'h0);
      chk($sformatf("postrst%0d_rise", k), o_rise, (k == 5) ? base : 21'h0);
    end

    // Randomized traffic against the reference
    step(1, 0);
    r = '0;
    for (int c = 0; c < 1500; c++) begin
      flip = '0;
      for (int b = 0; b < W; b++) flip[b] = ($urandom_range(0, 9) == 0);
      r = r ^ flip;
      step(($urandom_range(0, 199) == 0), r);
      chk("rnd_data", o_data, m_data);
      chk("rnd_rise", o_rise, m_rise);
      chk("rnd_fall", o_fall, m_fall);
      chk("rnd_chg", W'(o_changed), W'(|(m_rise | m_fall)));
      chk("rnd_excl", o_rise & o_fall, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_input_debounce.md
GPIO_INPUT_DEBOUNCE -- requirements
Module: gpio_input_debounce

Interface
REQ-001 Parameter WIDTH, default 21, number of input lines (buttons[4:0] concatenated above switches[15:0]).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth; legal range 2..4.
REQ-003 Parameter DEBOUNCE_CYCLES, default 1_000_000, consecutive stable cycles required to accept a change; legal range >= 1.
REQ-004 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 i_reset  input  1  synchronous, active-high reset.
REQ-006 i_raw  input  WIDTH  asynchronous switch/button levels from pads.
REQ-007 o_data  output  WIDTH  debounced levels, drives rv_soc i_data directly.
REQ-008 o_rise  output  WIDTH  one-cycle pulse per bit on accepted 0->1 change.
REQ-009 o_fall  output  WIDTH  one-cycle pulse per bit on accepted 1->0 change.
REQ-010 o_changed  output  1  OR of all o_rise and o_fall bits, same cycle.

Function
REQ-011 Each bit SHALL pass through a SYNC_STAGES-deep flop chain; last stage = sync[i]; no logic between chain flops.
REQ-012 Each bit SHALL hold a stable[i] register driving o_data[i] and a counter cnt[i] of width clog2(DEBOUNCE_CYCLES+1).
REQ-013 Per-bit states: IDLE (sync==stable, cnt==0) and COUNTING (sync!=stable); no other state encoding.
REQ-014 IDLE: when sync!=stable, cnt <= 1 and move to COUNTING; when DEBOUNCE_CYCLES==1, accept immediately instead (REQ-016).
REQ-015 COUNTING: if sync==stable, cnt <= 0, return to IDLE, no pulse; else cnt increments.
REQ-016 Accept: in the cycle sync!=stable and cnt==DEBOUNCE_CYCLES-1, stable <= sync, cnt <= 0, next state IDLE, and registered o_rise/o_fall for that bit asserted for exactly the following cycle, aligned with the new o_data.
REQ-017 Latency: input held constant from first sampling edge E0 SHALL appear on o_data after edge E0+SYNC_STAGES+DEBOUNCE_CYCLES-1.
REQ-018 Any mismatch shorter than DEBOUNCE_CYCLES consecutive sync cycles SHALL produce no o_data change and no pulse.
REQ-019 Counter SHALL never wrap; saturation impossible because accept clears it at DEBOUNCE_CYCLES-1.
REQ-020 Bits SHALL be fully independent; simultaneous accepts on several bits SHALL all pulse in the same cycle.
REQ-021 o_rise[i] and o_fall[i] SHALL never be high together; o_changed SHALL be registered-equivalent timing with the pulses (derived combinationally from registered pulses).

Reset
REQ-022 i_reset high at an edge SHALL clear all sync flops, stable (o_data=0), cnt, o_rise, o_fall, o_changed to 0.
REQ-023 Reset mid-count SHALL discard the partial count; with input held after release, full REQ-017 latency applies again from the first post-reset edge.
REQ-024 A line already high at reset release SHALL be accepted after full latency and produce one o_rise pulse.

Structure
REQ-025 GPIO_IN_WIDTH (21) and DEBOUNCE_CYCLES default SHALL live in the shared SoC package/header, also used by rv_soc.
REQ-026 One sub-module debounce_bit (sync chain, counter, stable, pulse flops for one line) SHALL be instantiated WIDTH times via generate; top adds only o_changed reduction.
REQ-027 No clock enables, no multicycle paths; fully synthesizable, no initial blocks for function.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, WIDTH=21)
REQ-028 Reset with i_raw=21'h1FFFFF held high -> all outputs 0 during reset; after release o_data=21'h1FFFFF at edge 5 post-release, o_rise=21'h1FFFFF for one cycle.
REQ-029 i_raw[0] 0->1 held -> o_data[0]=1 exactly 5 edges after first sampling edge; o_rise[0], o_changed high one cycle; o_fall=0.
REQ-030 i_raw[5] high for 3 cycles then low -> o_data[5] stays 0, no pulse on any output.
REQ-031 i_raw[7] bounce 1,0,1,1,1,1 (one value per cycle) -> counter restarts at the 0; o_data[7]=1 only after 4 consecutive synced 1s; one o_rise pulse.
REQ-032 Same-cycle i_raw[20] 0->1 and i_raw[3] 1->0 (bit 3 previously accepted high) -> o_rise[20] and o_fall[3] pulse same cycle; o_changed one cycle.
REQ-033 i_reset asserted when bit 2 cnt==2 -> cnt cleared, o_data[2]=0; after release with input high, acceptance after full 5-edge latency.
